// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM encoding, reset PC and the NOP word.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0040_0020;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } ifetch_state_t;

endpackage

// File: rtl/ifetch_skid.sv
// One-entry skid buffer parking a fetched {instr, pc_plus4} while decode stalls.
module ifetch_skid #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  logic [W-1:0] instr_in,
  input  logic [W-1:0] pc_plus4_in,
  output logic         full,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc_plus4
);
  import mips_pkg::*;

  // Clear (redirect) wins over a same-cycle load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      instr    <= W'(NOP_INSTR);
      pc_plus4 <= '0;
    end else begin
      if (clear) begin
        full <= 1'b0;
      end else if (load) begin
        full <= 1'b1;
      end else if (unload) begin
        full <= 1'b0;
      end
      if (load && !clear) begin
        instr    <= instr_in;
        pc_plus4 <= pc_plus4_in;
      end
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: one outstanding word request, IF/ID slot with a
// one-entry skid, and redirect handling that replays a flushed request to completion.
module ifetch_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(mips_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_f,
  output logic              pc_enable,
  input  logic              stall_d,
  input  logic              flush_d,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic              valid_d,
  output logic [ADDR_W-1:0] instr_d,
  output logic [ADDR_W-1:0] pc_plus4_d
);
  import mips_pkg::*;

  ifetch_state_t     state;
  ifetch_state_t     state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pc_plus4_f;
  logic              can_accept;

  logic              slot_mem;
  logic              slot_skid;
  logic              slot_drop;
  logic              skid_load;
  logic              skid_unload;
  logic              skid_clear;
  logic              skid_full;
  logic [ADDR_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc_plus4;

  assign pc_plus4_f = pc_f + ADDR_W'(4);
  assign can_accept = !valid_d || !stall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle controls; a redirect overrides stall and ready.
  always_comb begin
    state_next  = state;
    pc_enable   = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = addr_q;
    slot_mem    = 1'b0;
    slot_skid   = 1'b0;
    slot_drop   = 1'b0;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;
    case (state)
      IDLE: begin
        state_next = FETCH;
        if (flush_d) begin
          slot_drop  = 1'b1;
          skid_clear = 1'b1;
        end
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_f;
        if (flush_d) begin
          pc_enable  = 1'b1;
          slot_drop  = 1'b1;
          skid_clear = 1'b1;
          state_next = mem_ready ? FETCH : DRAIN;
        end else if (mem_ready) begin
          pc_enable = 1'b1;
          if (can_accept) begin
            slot_mem = 1'b1;
          end else begin
            skid_load  = 1'b1;
            state_next = HOLD;
          end
        end else if (!stall_d) begin
          slot_drop = 1'b1;
        end
      end
      HOLD: begin
        if (flush_d) begin
          pc_enable  = 1'b1;
          slot_drop  = 1'b1;
          skid_clear = 1'b1;
          state_next = FETCH;
        end else if (!stall_d) begin
          slot_skid   = 1'b1;
          skid_unload = 1'b1;
          state_next  = FETCH;
        end
      end
      DRAIN: begin
        mem_req = 1'b1;
        if (flush_d) begin
          pc_enable  = 1'b1;
          slot_drop  = 1'b1;
          skid_clear = 1'b1;
        end else if (mem_ready) begin
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address of the outstanding request, replayed while draining a flushed fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= RESET_PC;
    end else if (state == FETCH) begin
      addr_q <= pc_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d    <= 1'b0;
      instr_d    <= ADDR_W'(NOP_INSTR);
      pc_plus4_d <= '0;
    end else if (slot_mem) begin
      valid_d    <= 1'b1;
      instr_d    <= mem_rdata;
      pc_plus4_d <= pc_plus4_f;
    end else if (slot_skid) begin
      valid_d    <= skid_full;
      instr_d    <= skid_instr;
      pc_plus4_d <= skid_pc_plus4;
    end else if (slot_drop) begin
      valid_d    <= 1'b0;
    end
  end

  ifetch_skid #(
    .W (ADDR_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (skid_load),
    .unload      (skid_unload),
    .clear       (skid_clear),
    .instr_in    (mem_rdata),
    .pc_plus4_in (pc_plus4_f),
    .full        (skid_full),
    .instr       (skid_instr),
    .pc_plus4    (skid_pc_plus4)
  );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios plus random traffic against a
// queue-based model of the IF/ID slot, outstanding request and PC register.
module tb_ifetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0040_0020;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        pc_enable;
  logic        stall_d;
  logic        flush_d;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_d;

  int checks = 0;
  int errors = 0;

  // Model: q[0] is the IF/ID slot, q[1] a parked instruction; drain marks a stale request.
  bit          started;
  bit          drain;
  logic [31:0] drain_addr;
  ent_t        q[$];

  ifetch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_f       (pc_f),
    .pc_enable  (pc_enable),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .valid_d    (valid_d),
    .instr_d    (instr_d),
    .pc_plus4_d (pc_plus4_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_slot();
    chk("valid_d", 32'(valid_d), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("instr_d", instr_d, q[0].instr);
      chk("pc_plus4_d", pc_plus4_d, q[0].pc4);
    end
  endtask

  task automatic model_reset();
    started = 1'b0;
    drain   = 1'b0;
    drain_addr = RST_PC;
    q.delete();
    pc_f = RST_PC;
  endtask

  // One clock: check slot, drive inputs, check request side, then advance model and PC.
  task automatic step(input bit st, input bit fl, input bit rdy_want, input logic [31:0] tgt);
    logic        exp_req;
    logic        exp_pen;
    logic [31:0] exp_addr;
    logic [31:0] rdata;
    bit          rdy;
    @(negedge clk);
    chk_slot();
    exp_req  = started && (q.size() < 2);
    rdy      = rdy_want && exp_req;
    rdata    = $urandom;
    exp_addr = drain ? drain_addr : pc_f;
    exp_pen  = started && (fl || ((q.size() < 2) && !drain && rdy));
    stall_d   = st;
    flush_d   = fl;
    mem_ready = rdy;
    mem_rdata = rdata;
    #1;
    chk("mem_req", 32'(mem_req), 32'(exp_req));
    chk("pc_enable", 32'(pc_enable), 32'(exp_pen));
    if (exp_req) chk("mem_addr", mem_addr, exp_addr);
    @(posedge clk);
    #1;
    if (!started) begin
      started = 1'b1;
    end else if (fl) begin
      if (q.size() < 2 && !drain) begin
        drain      = !rdy;
        drain_addr = pc_f;
      end
      q.delete();
    end else if (q.size() == 2) begin
      if (!st) void'(q.pop_front());
    end else if (drain) begin
      if (rdy) drain = 1'b0;
    end else begin
      if (q.size() == 1 && !st) void'(q.pop_front());
      if (rdy) q.push_back({rdata, pc_f + 32'd4});
    end
    if (exp_pen) pc_f = fl ? tgt : pc_f + 32'd4;
  endtask

  initial begin
    rst_n     = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h2008_0005;
    model_reset();
    #1;
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst pc_enable", 32'(pc_enable), 32'd0);
    chk("rst valid_d", 32'(valid_d), 32'd0);
    chk("rst instr_d", instr_d, 32'd0);
    chk("rst pc_plus4_d", pc_plus4_d, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Zero-wait stream.
    repeat (4) step(1'b0, 1'b0, 1'b1, 32'd0);
    // Three wait cycles.
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'd0);
    // Stall with full slot when ready arrives, then release.
    step(1'b1, 1'b0, 1'b1, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'd0);
    // Flush during a wait, drain, then fetch from the target.
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0040_0100);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'd0);
    // Flush together with stall while holding.
    step(1'b1, 1'b0, 1'b1, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC);
    // Fetch at the top of the address space wraps pc_plus4.
    step(1'b0, 1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, t);
    end

    // Reset asserted while a request waits.
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("midrst mem_req", 32'(mem_req), 32'd0);
    chk("midrst pc_enable", 32'(pc_enable), 32'd0);
    chk("midrst valid_d", 32'(valid_d), 32'd0);
    chk("midrst instr_d", instr_d, 32'd0);
    chk("midrst pc_plus4_d", pc_plus4_d, 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (30) step($urandom_range(0, 9) < 3, 1'b0, $urandom_range(0, 1) == 1, 32'd0);
    @(negedge clk);
    chk_slot();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
